interface_ultrassom_param: RTL and testbench
============================================

Name: interface_ultrassom_param

Overview:
- Parametrised HC-SR04-style ultrasonic ranging interface: generates the trigger pulse, measures echo width, converts to centimetres directly in BCD.
- Adds single-shot and continuous modes, echo timeout and BCD saturation.
- Sits between the sensor pins and the display/serial transmit logic of the trena system (50 MHz board clock).

Parameters:
TRIGGER_CICLOS, 500, trigger high time in clock cycles (10 us at 50 MHz)
CICLOS_POR_CM, 2941, clock cycles of echo per centimetre (58.82 us / 20 ns)
DIGITOS, 3, number of BCD digits in medida
TIMEOUT_CICLOS, 1_500_000, max wait for echo rise, and separately max echo high time (30 ms)
INTERVALO_CICLOS, 5_000_000, idle gap between measurements in continuous mode (100 ms)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
medir  in  1  start request, sampled level; acted on only in inicial
modo_continuo  in  1  1 = re-measure automatically every INTERVALO_CICLOS
echo  in  1  sensor echo, asynchronous
trigger  out  1  sensor trigger pulse
medida  out  4*DIGITOS  BCD distance, digit 0 in bits [3:0]
pronto  out  1  one-cycle pulse when medida updated
timeout  out  1  sticky error flag
db_estado  out  4  current FSM state code

Behaviour:
- Reset (async, any state): FSM to inicial; trigger=0, medida=0, pronto=0, timeout=0, all counters 0, synchroniser flops 0.
- echo passes a 2-flop synchroniser; all echo decisions use the synchronised signal (2-cycle latency).
- States and codes:
  - inicial (0): idle. medir=1 -> preparacao.
  - preparacao (1): one cycle; clears counters and timeout; BCD accumulator to 0 (medida itself unchanged).
  - envia_trigger (2): trigger=1 for exactly TRIGGER_CICLOS cycles -> espera_echo.
  - espera_echo (3): waits for synchronised echo rising edge -> mede. If TIMEOUT_CICLOS elapse first -> erro.
  - mede (4): while echo high, sub-counter counts 0..CICLOS_POR_CM-1. On wrap, BCD accumulator +1 with decimal carry across DIGITOS digits. Echo falling edge -> armazena. Echo high for TIMEOUT_CICLOS cycles -> erro.
  - armazena (5): rounds up by 1 if sub-counter >= CICLOS_POR_CM/2 (integer division). Copies accumulator to medida -> final.
  - final (6): pronto=1 for this single cycle. modo_continuo=1 -> intervalo, else inicial.
  - erro (7): timeout=1 (stays set until next preparacao); medida holds previous value; no pronto. Next state same as final.
  - intervalo (8): waits INTERVALO_CICLOS cycles -> preparacao. If modo_continuo drops -> inicial immediately.
- Saturation: once accumulator is all 9s, further increments and round-up are ignored. No wrap to 0.
- medir is ignored outside inicial.
- Echo already high on entry to espera_echo is not an edge; wait for low then high.
- Echo pulses during inicial/intervalo are ignored.
- modo_continuo is sampled only in final/erro/intervalo.

Test Plan:
- Default params, medir pulse 100 ns, echo high 5_882_000 ns starting 400 us later -> trigger high exactly 10 us; medida=12'h100; one pronto pulse; timeout=0; db_estado back to 0.
- Echo width 1471 cycles -> medida=12'h001 (round up). Width 1469 cycles -> medida=12'h000 with pronto.
- DIGITOS=2, echo 5_882_000 ns (100 cm) -> medida=8'h99 (saturated), pronto pulses.
- No echo after trigger -> after 1_500_000 cycles timeout=1, no pronto, medida keeps prior 12'h100. Next medir clears timeout.
- modo_continuo=1, echo responder 1176.4 us per trigger -> medida=12'h020 each cycle; pronto pulses spaced 5_000_000 cycles plus measurement time. Drop modo_continuo during intervalo -> db_estado=0 next cycle.
- Assert reset mid-mede -> trigger=0, medida=0, db_estado=0 immediately (before next clock edge).

Source files
------------

// File: rtl/interface_ultrassom_param.sv
// HC-SR04-style ultrasonic ranging interface: trigger generation, echo width
// measurement straight into saturating BCD centimetres, single-shot or continuous.
module interface_ultrassom_param #(
    parameter int TRIGGER_CICLOS   = 500,
    parameter int CICLOS_POR_CM    = 2941,
    parameter int DIGITOS          = 3,
    parameter int TIMEOUT_CICLOS   = 1_500_000,
    parameter int INTERVALO_CICLOS = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   medir,
    input  logic                   modo_continuo,
    input  logic                   echo,
    output logic                   trigger,
    output logic [4*DIGITOS-1:0]   medida,
    output logic                   pronto,
    output logic                   timeout,
    output logic [3:0]             db_estado
);

    localparam int MED_W  = 4 * DIGITOS;
    localparam int MAX_A  = (TIMEOUT_CICLOS > INTERVALO_CICLOS) ? TIMEOUT_CICLOS : INTERVALO_CICLOS;
    localparam int MAX_C  = (MAX_A > TRIGGER_CICLOS) ? MAX_A : TRIGGER_CICLOS;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int SUB_W  = $clog2(CICLOS_POR_CM + 1);

    typedef enum logic [3:0] {
        ST_INICIAL    = 4'd0,
        ST_PREPARACAO = 4'd1,
        ST_ENVIA_TRIG = 4'd2,
        ST_ESPERA     = 4'd3,
        ST_MEDE       = 4'd4,
        ST_ARMAZENA   = 4'd5,
        ST_FINAL      = 4'd6,
        ST_ERRO       = 4'd7,
        ST_INTERVALO  = 4'd8
    } estado_t;

    estado_t            estado, estado_next;
    logic               echo_p0, echo_p1, echo_p2;
    logic [CNT_W-1:0]   cnt;
    logic [SUB_W-1:0]   sub;
    logic [MED_W-1:0]   acc;
    logic               echo_rise, echo_low;

    function automatic logic bcd_all9(input logic [MED_W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITOS; i++)
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        return r;
    endfunction

    // Decimal increment that sticks at all nines instead of wrapping.
    function automatic logic [MED_W-1:0] bcd_sat_inc(input logic [MED_W-1:0] v);
        logic [MED_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        if (!bcd_all9(v)) begin
            for (int i = 0; i < DIGITOS; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign echo_rise = echo_p1 & ~echo_p2;
    assign echo_low  = ~echo_p1;
    assign trigger   = (estado == ST_ENVIA_TRIG);
    assign pronto    = (estado == ST_FINAL);
    assign db_estado = estado;

    always_comb begin
        estado_next = estado;
        case (estado)
            ST_INICIAL:    if (medir) estado_next = ST_PREPARACAO;
            ST_PREPARACAO: estado_next = ST_ENVIA_TRIG;
            ST_ENVIA_TRIG: if (cnt == CNT_W'(TRIGGER_CICLOS - 1)) estado_next = ST_ESPERA;
            ST_ESPERA: begin
                if (echo_rise)                                 estado_next = ST_MEDE;
                else if (cnt == CNT_W'(TIMEOUT_CICLOS - 1))    estado_next = ST_ERRO;
            end
            ST_MEDE: begin
                if (echo_low)                                  estado_next = ST_ARMAZENA;
                else if (cnt == CNT_W'(TIMEOUT_CICLOS - 1))    estado_next = ST_ERRO;
            end
            ST_ARMAZENA:   estado_next = ST_FINAL;
            ST_FINAL,
            ST_ERRO:       estado_next = modo_continuo ? ST_INTERVALO : ST_INICIAL;
            ST_INTERVALO: begin
                if (!modo_continuo)                            estado_next = ST_INICIAL;
                else if (cnt == CNT_W'(INTERVALO_CICLOS - 1))  estado_next = ST_PREPARACAO;
            end
            default:       estado_next = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= ST_INICIAL;
            echo_p0 <= 1'b0;
            echo_p1 <= 1'b0;
            echo_p2 <= 1'b0;
            cnt     <= '0;
            sub     <= '0;
            acc     <= '0;
            medida  <= '0;
            timeout <= 1'b0;
        end else begin
            estado  <= estado_next;
            // synchroniser p0/p1, p2 holds the previous synchronised sample for edges
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
            echo_p2 <= echo_p1;
            case (estado)
                ST_PREPARACAO: begin
                    cnt     <= '0;
                    sub     <= '0;
                    acc     <= '0;
                    timeout <= 1'b0;
                end
                ST_ENVIA_TRIG: cnt <= (cnt == CNT_W'(TRIGGER_CICLOS - 1)) ? '0 : cnt + 1'b1;
                ST_ESPERA: begin
                    // the rising-edge cycle is already the first high cycle of the echo
                    if (echo_rise) begin
                        cnt <= CNT_W'(1);
                        sub <= SUB_W'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_MEDE: begin
                    if (!echo_low) begin
                        cnt <= cnt + 1'b1;
                        if (sub == SUB_W'(CICLOS_POR_CM - 1)) begin
                            sub <= '0;
                            acc <= bcd_sat_inc(acc);
                        end else begin
                            sub <= sub + 1'b1;
                        end
                    end
                end
                ST_ARMAZENA:
                    medida <= (sub >= SUB_W'(CICLOS_POR_CM / 2)) ? bcd_sat_inc(acc) : acc;
                ST_INTERVALO:  cnt <= cnt + 1'b1;
                default:       cnt <= '0;
            endcase
            if (estado_next == ST_ERRO) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_interface_ultrassom_param.sv
// Bench for interface_ultrassom_param with shrunk timing parameters: vector table,
// randomized widths against an arithmetic distance model, and corner sequences.
module tb_interface_ultrassom_param;

    localparam int TRIG  = 5;
    localparam int CPC   = 4;
    localparam int DIG   = 3;
    localparam int TOUT  = 5000;
    localparam int INTV  = 300;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              medir = 1'b0;
    logic              modo_continuo = 1'b0;
    logic              echo = 1'b0;
    logic              trigger;
    logic [4*DIG-1:0]  medida;
    logic              pronto;
    logic              timeout;
    logic [3:0]        db_estado;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    interface_ultrassom_param #(
        .TRIGGER_CICLOS(TRIG), .CICLOS_POR_CM(CPC), .DIGITOS(DIG),
        .TIMEOUT_CICLOS(TOUT), .INTERVALO_CICLOS(INTV)
    ) dut (
        .clock(clock), .reset(reset), .medir(medir), .modo_continuo(modo_continuo),
        .echo(echo), .trigger(trigger), .medida(medida), .pronto(pronto),
        .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Distance in cm: whole centimetres, rounded up on half or more, clamped to 999.
    function automatic logic [11:0] model(input int w);
        int cm;
        logic [3:0] d2, d1, d0;
        cm = w / CPC + (((w % CPC) >= (CPC / 2)) ? 1 : 0);
        if (cm > 999) cm = 999;
        d2 = 4'(cm / 100);
        d1 = 4'((cm / 10) % 10);
        d0 = 4'(cm % 10);
        return {d2, d1, d0};
    endfunction

    task automatic pulse_medir();
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
    endtask

    task automatic wait_trigger_done(output int trig_len);
        int k;
        k = 0;
        while (!trigger && k < INTV + 50) begin @(negedge clock); k++; end
        trig_len = 0;
        while (trigger && trig_len < 1000) begin @(negedge clock); trig_len++; end
    endtask

    task automatic do_measure(input int width, input int gap, output logic [11:0] got,
                              output int n_pronto, output int trig_len, output bit saw_to);
        pulse_medir();
        wait_trigger_done(trig_len);
        repeat (gap) @(negedge clock);
        echo = 1'b1;
        repeat (width) @(negedge clock);
        echo = 1'b0;
        n_pronto = 0;
        saw_to   = 1'b0;
        got      = medida;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (pronto) begin n_pronto++; got = medida; end
            if (timeout) saw_to = 1'b1;
        end
    endtask

    typedef struct {
        int          width;
        logic [11:0] exp;
    } vec_t;

    vec_t        tbl[11];
    logic [11:0] got, prev;
    int          np, tl, w, t1, t2, k;
    bit          to;

    initial begin
        tbl[0]  = '{1,    12'h000};
        tbl[1]  = '{2,    12'h001};
        tbl[2]  = '{4,    12'h001};
        tbl[3]  = '{5,    12'h001};
        tbl[4]  = '{6,    12'h002};
        tbl[5]  = '{7,    12'h002};
        tbl[6]  = '{400,  12'h100};
        tbl[7]  = '{3993, 12'h998};
        tbl[8]  = '{3995, 12'h999};
        tbl[9]  = '{3998, 12'h999};
        tbl[10] = '{4100, 12'h999};

        repeat (2) @(negedge clock);
        chk("reset_medida", 32'(medida), 32'h0);
        chk("reset_trigger", 32'(trigger), 32'h0);
        chk("reset_flags", {30'b0, pronto, timeout}, 32'h0);
        chk("reset_estado", 32'(db_estado), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            do_measure(tbl[i].width, 7, got, np, tl, to);
            chk($sformatf("tbl%0d_medida", i), 32'(got), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_pronto", i), 32'(np), 32'd1);
            chk($sformatf("tbl%0d_trig_len", i), 32'(tl), 32'(TRIG));
            chk($sformatf("tbl%0d_timeout", i), 32'(to), 32'd0);
            chk($sformatf("tbl%0d_estado", i), 32'(db_estado), 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(1, 4200);
            do_measure(w, $urandom_range(0, 30), got, np, tl, to);
            chk($sformatf("rand%0d_w%0d_medida", i, w), 32'(got), 32'(model(w)));
            chk($sformatf("rand%0d_pronto", i), 32'(np), 32'd1);
        end

        // set a known medida, then let the echo never come
        do_measure(400, 3, got, np, tl, to);
        prev = medida;
        chk("pre_timeout_medida", 32'(prev), 32'h100);
        pulse_medir();
        np = 0;
        for (int i = 0; i < TOUT + 60; i++) begin
            @(negedge clock);
            if (pronto) np++;
        end
        chk("noecho_timeout", 32'(timeout), 32'd1);
        chk("noecho_pronto", 32'(np), 32'd0);
        chk("noecho_medida_held", 32'(medida), 32'(prev));
        chk("noecho_estado", 32'(db_estado), 32'd0);
        pulse_medir();
        @(negedge clock);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        wait_trigger_done(tl);
        repeat (4) @(negedge clock);
        echo = 1'b1; repeat (12) @(negedge clock); echo = 1'b0;
        repeat (20) @(negedge clock);
        chk("after_timeout_medida", 32'(medida), 32'h003);

        // echo stuck high beyond the limit
        do_measure(TOUT + 100, 2, got, np, tl, to);
        chk("longecho_timeout", 32'(to), 32'd1);
        chk("longecho_pronto", 32'(np), 32'd0);
        chk("longecho_medida_held", 32'(medida), 32'h003);

        // echo already high when waiting starts must not count as an edge
        echo = 1'b1;
        pulse_medir();
        wait_trigger_done(tl);
        repeat (20) @(negedge clock);
        echo = 1'b0;
        repeat (5) @(negedge clock);
        echo = 1'b1; repeat (8) @(negedge clock); echo = 1'b0;
        np = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (pronto) np++;
        end
        chk("prehigh_medida", 32'(medida), 32'h002);
        chk("prehigh_pronto", 32'(np), 32'd1);

        // continuous mode: 80 cycles of echo = 20 cm per round
        modo_continuo = 1'b1;
        pulse_medir();
        t1 = 0;
        t2 = 0;
        for (int r = 0; r < 2; r++) begin
            wait_trigger_done(tl);
            chk($sformatf("cont%0d_trig_len", r), 32'(tl), 32'(TRIG));
            repeat (10) @(negedge clock);
            echo = 1'b1; repeat (80) @(negedge clock); echo = 1'b0;
            k = 0;
            while (!pronto && k < 50) begin @(negedge clock); k++; end
            chk($sformatf("cont%0d_pronto_seen", r), 32'(pronto), 32'd1);
            chk($sformatf("cont%0d_medida", r), 32'(medida), 32'h020);
            if (r == 0) t1 = cyc; else t2 = cyc;
            @(negedge clock);
        end
        chk("cont_spacing_ok", 32'((t2 - t1) >= INTV + TRIG + 80 && (t2 - t1) <= INTV + TRIG + 130), 32'd1);
        k = 0;
        while (db_estado != 4'd8 && k < 20) begin @(negedge clock); k++; end
        chk("cont_in_intervalo", 32'(db_estado), 32'd8);
        repeat (50) @(negedge clock);
        modo_continuo = 1'b0;
        @(negedge clock);
        chk("cont_drop_to_inicial", 32'(db_estado), 32'd0);
        repeat (INTV + 20) @(negedge clock);
        chk("cont_stays_idle", 32'(db_estado), 32'd0);

        // asynchronous reset in the middle of a measurement
        pulse_medir();
        wait_trigger_done(tl);
        echo = 1'b1;
        k = 0;
        while (db_estado != 4'd4 && k < 20) begin @(negedge clock); k++; end
        chk("midmede_reached", 32'(db_estado), 32'd4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_trigger", 32'(trigger), 32'd0);
        chk("async_rst_medida", 32'(medida), 32'h0);
        chk("async_rst_estado", 32'(db_estado), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        echo  = 1'b0;
        repeat (3) @(negedge clock);
        do_measure(40, 5, got, np, tl, to);
        chk("post_reset_medida", 32'(got), 32'h010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
